// File: rtl/pingpong_reader.sv
// Read-side controller for a two-bank ping-pong buffer: drains a full bank from a
// synchronous RAM through a 2-entry skid buffer onto a valid/ready stream.
module pingpong_reader #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [1:0]    bank_full,
    output logic [1:0]    bank_release,
    output logic          ram_rd_en,
    output logic [AW:0]   ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          cur_bank,
    output logic [1:0]    state,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_cur_bank;
    logic [AW-1:0] r_issue_cnt;
    logic          r_words_left;
    logic          r_inflight;
    logic          r_inflight_last;
    logic          r_err;

    // Skid buffer entries carry {last, data}
    logic [DW:0]   r_fifo [2];
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [1:0]    r_occ;

    logic          w_pop;
    logic          w_rd_en;
    logic          w_cnt_max;
    logic [DW:0]   w_head;
    logic [2:0]    w_pending;

    assign w_head    = r_fifo[r_rd_ptr];
    assign w_pop     = out_valid && out_ready;
    assign w_cnt_max = &r_issue_cnt;

    // Words already committed to the buffer after this cycle's pop; a new read
    // is only safe while that leaves room for the word it will return.
    assign w_pending = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_rd_en   = (r_state == ST_READ) && r_words_left && (w_pending < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cur_bank   <= 1'b0;
            r_issue_cnt  <= '0;
            r_words_left <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= only, so every branch below sees
            // the pre-edge values of all registers regardless of statement order.
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state     <= ST_WAIT;
                        r_issue_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bank_full[r_cur_bank]) begin
                        r_state      <= ST_READ;
                        r_issue_cnt  <= '0;
                        r_words_left <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_rd_en) begin
                        if (w_cnt_max) r_words_left <= 1'b0;
                        else           r_issue_cnt  <= r_issue_cnt + 1'b1;
                    end
                    if (!bank_full[r_cur_bank]) r_err <= 1'b1;
                    if (w_pop && w_head[DW])    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!bank_full[r_cur_bank]) r_err <= 1'b1;
                    r_cur_bank  <= ~r_cur_bank;
                    r_issue_cnt <= '0;
                    r_state     <= run ? ST_WAIT : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two skid entries are reset so out_data reads 0 out of
            // reset; a real RAM array would be left unreset.
            r_fifo[0]       <= '0;
            r_fifo[1]       <= '0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_occ           <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && w_cnt_max;
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= {r_inflight_last, ram_dout};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
        end
    end

    assign ram_rd_en    = w_rd_en;
    assign ram_addr     = {r_cur_bank, r_issue_cnt};
    assign out_data     = w_head[DW-1:0];
    assign out_valid    = (r_occ != 2'd0);
    assign out_last     = out_valid && w_head[DW];
    assign cur_bank     = r_cur_bank;
    assign state        = r_state;
    assign err          = r_err;
    assign bank_release = (r_state == ST_DONE) ? (r_cur_bank ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_pingpong_reader.sv
// Directed bench for pingpong_reader with AW=2: latency, backpressure, bank
// alternation, run drop, error flag and asynchronous reset.
module tb_pingpong_reader;

    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [1:0]    bank_full;
    logic [1:0]    bank_release;
    logic          ram_rd_en;
    logic [AW:0]   ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          cur_bank;
    logic [1:0]    state;
    logic          err;

    logic [DW-1:0] ram [2*DEPTH];

    int total = 0;
    int bad   = 0;

    pingpong_reader #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .ram_rd_en    (ram_rd_en),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .cur_bank     (cur_bank),
        .state        (state),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd_en) ram_dout <= ram[ram_addr];

    function automatic logic [DW-1:0] exp_word(input int b, input int k);
        return 16'h5A00 + 16'((b * DEPTH + k) * 17);
    endfunction

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; bank_full = 2'b00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_read();
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (state !== 2'd2 && n < 10);
    endtask

    task automatic test_reset();
        int n = 0;
        rst = 1'b1; run = 1'b0; bank_full = 2'b00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; run = 1'b1; bank_full = 2'b01;
        do begin @(negedge clk); #1; n++; end while (out_valid !== 1'b1 && n < 12);
        total++;
        if (out_valid !== 1'b1 || state !== 2'd2) begin
            bad++; $display("FAIL reset_pre: valid=%b state=%0d want valid=1 state=2", out_valid, state);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({state, cur_bank, out_valid, out_last, ram_rd_en, bank_release, err} !== 9'd0) begin
            bad++; $display("FAIL reset_async_ctl: state=%0d bank=%b valid=%b last=%b rd=%b rel=%b err=%b want all 0",
                            state, cur_bank, out_valid, out_last, ram_rd_en, bank_release, err);
        end
        total++;
        if (out_data !== 16'd0 || ram_addr !== 3'd0) begin
            bad++; $display("FAIL reset_async_data: data=%h addr=%h want 0/0", out_data, ram_addr);
        end
        @(negedge clk);
        rst = 1'b0; run = 1'b0; bank_full = 2'b00;
        repeat (2) begin @(negedge clk); #1; end
        total++;
        if (state !== 2'd0 || cur_bank !== 1'b0 || bank_release !== 2'b00) begin
            bad++; $display("FAIL reset_after: state=%0d bank=%b rel=%b want 0/0/00", state, cur_bank, bank_release);
        end
    endtask

    task automatic test_basic();
        logic          exp_rd, exp_valid, exp_last;
        logic [1:0]    exp_rel;
        do_reset();
        run = 1'b1; out_ready = 1'b1; bank_full = 2'b01;
        @(negedge clk); #1;
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL basic_wait: state=%0d want 1", state);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); #1;
            exp_rd    = (c >= 1 && c <= 4);
            exp_valid = (c >= 3 && c <= 6);
            exp_last  = (c == 6);
            exp_rel   = (c == 7) ? 2'b01 : 2'b00;
            total++;
            if (ram_rd_en !== exp_rd || (exp_rd && ram_addr !== 3'(c - 1))) begin
                bad++; $display("FAIL basic_rd c=%0d: rd=%b addr=%0d want rd=%b addr=%0d", c, ram_rd_en, ram_addr, exp_rd, c - 1);
            end
            total++;
            if (out_valid !== exp_valid || out_last !== exp_last ||
                (exp_valid && out_data !== exp_word(0, c - 3))) begin
                bad++; $display("FAIL basic_out c=%0d: valid=%b last=%b data=%h want valid=%b last=%b data=%h",
                                c, out_valid, out_last, out_data, exp_valid, exp_last, exp_word(0, c - 3));
            end
            total++;
            if (bank_release !== exp_rel) begin
                bad++; $display("FAIL basic_rel c=%0d: rel=%b want %b", c, bank_release, exp_rel);
            end
            if (c == 7) begin
                total++;
                if (state !== 2'd3) begin bad++; $display("FAIL basic_done: state=%0d want 3", state); end
            end
            if (c == 8) begin
                total++;
                if (state !== 2'd1 || cur_bank !== 1'b1 || err !== 1'b0) begin
                    bad++; $display("FAIL basic_next: state=%0d bank=%b err=%b want 1/1/0", state, cur_bank, err);
                end
                bank_full = 2'b00;
            end
        end
    endtask

    task automatic test_backpressure();
        int got = 0, rel = 0, occ = 0, infl = 0;
        logic prev_rd = 0, prev_pop = 0, prev_stall = 0, pop, pl = 0;
        logic [DW-1:0] pd = '0;
        do_reset();
        run = 1'b1; bank_full = 2'b01;
        for (int cyc = 0; cyc < 60 && rel == 0; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0);
            #1;
            occ  = occ + infl - int'(prev_pop);
            infl = int'(prev_rd);
            pop  = out_valid && out_ready;
            if (ram_rd_en) begin
                total++;
                if (occ + infl - int'(pop) >= 2) begin
                    bad++; $display("FAIL bp_rd_guard cyc=%0d: rd=1 with occ=%0d inflight=%0d pop=%b want rd=0", cyc, occ, infl, pop);
                end
            end
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    bad++; $display("FAIL bp_stable cyc=%0d: valid=%b data=%h last=%b want 1/%h/%b", cyc, out_valid, out_data, out_last, pd, pl);
                end
            end
            if (pop) begin
                total++;
                if (out_data !== exp_word(0, got) || out_last !== (got == 3)) begin
                    bad++; $display("FAIL bp_word %0d: data=%h last=%b want %h/%b", got, out_data, out_last, exp_word(0, got), got == 3);
                end
                got++;
            end
            if (bank_release !== 2'b00) begin
                total++;
                if (bank_release !== 2'b01 || got != 4) begin
                    bad++; $display("FAIL bp_rel: rel=%b words=%0d want 01/4", bank_release, got);
                end
                rel++;
            end
            prev_rd    = ram_rd_en;
            prev_pop   = pop;
            prev_stall = out_valid && !out_ready;
            pd         = out_data;
            pl         = out_last;
        end
        total++;
        if (got != 4 || rel != 1) begin
            bad++; $display("FAIL bp_total: words=%0d releases=%0d want 4/1", got, rel);
        end
        @(negedge clk);
        bank_full = 2'b00;
    endtask

    task automatic test_both_banks();
        int pops = 0, rd_cnt = 0, rel = 0, rel_cyc = -10, pend = 0;
        logic [2:0] ea;
        logic [1:0] er;
        do_reset();
        run = 1'b1; out_ready = 1'b1; bank_full = 2'b11;
        for (int cyc = 0; cyc < 80 && rd_cnt < 9; cyc++) begin
            @(negedge clk);
            if (pend == 1)      bank_full[0] = 1'b0;
            else if (pend == 2) bank_full = 2'b01;
            pend = 0;
            #1;
            if (ram_rd_en) begin
                ea = 3'(((rd_cnt / 4) % 2) * 4 + rd_cnt % 4);
                total++;
                if (ram_addr !== ea) begin
                    bad++; $display("FAIL both_addr %0d: addr=%0d want %0d", rd_cnt, ram_addr, ea);
                end
                if (rd_cnt == 4) begin
                    total++;
                    if (cyc != rel_cyc + 2) begin
                        bad++; $display("FAIL both_gap: first bank1 read %0d cycles after release want 2", cyc - rel_cyc);
                    end
                end
                rd_cnt++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== exp_word((pops / 4) % 2, pops % 4) || out_last !== (pops % 4 == 3)) begin
                    bad++; $display("FAIL both_word %0d: data=%h last=%b want %h/%b", pops, out_data, out_last,
                                    exp_word((pops / 4) % 2, pops % 4), pops % 4 == 3);
                end
                pops++;
            end
            if (bank_release !== 2'b00) begin
                er = (rel == 0) ? 2'b01 : 2'b10;
                total++;
                if (bank_release !== er || pops != 4 * (rel + 1)) begin
                    bad++; $display("FAIL both_rel %0d: rel=%b words=%0d want %b/%0d", rel, bank_release, pops, er, 4 * (rel + 1));
                end
                rel++;
                rel_cyc = cyc;
                pend    = rel;
            end
        end
        total++;
        if (rel != 2 || rd_cnt != 9 || err !== 1'b0) begin
            bad++; $display("FAIL both_total: releases=%0d reads=%0d err=%b want 2/9/0", rel, rd_cnt, err);
        end
    endtask

    task automatic test_run_drop();
        int pops = 0, rel = 0;
        do_reset();
        run = 1'b1; out_ready = 1'b1; bank_full = 2'b01;
        wait_read();
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL drop_enter: state=%0d want 2", state); end
        run = 1'b0;
        for (int cyc = 0; cyc < 20 && rel == 0; cyc++) begin
            @(negedge clk); #1;
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== exp_word(0, pops)) begin
                    bad++; $display("FAIL drop_word %0d: data=%h want %h", pops, out_data, exp_word(0, pops));
                end
                pops++;
            end
            if (bank_release !== 2'b00) begin
                total++;
                if (bank_release !== 2'b01 || pops != 4) begin
                    bad++; $display("FAIL drop_rel: rel=%b words=%0d want 01/4", bank_release, pops);
                end
                rel++;
            end
        end
        @(negedge clk);
        bank_full = 2'b00;
        #1;
        total++;
        if (state !== 2'd0 || cur_bank !== 1'b1 || rel != 1) begin
            bad++; $display("FAIL drop_after: state=%0d bank=%b releases=%0d want 0/1/1", state, cur_bank, rel);
        end
    endtask

    task automatic test_err();
        int pops = 0, rel = 0;
        logic rel_seen = 1'b0;
        do_reset();
        run = 1'b1; out_ready = 1'b1; bank_full = 2'b01;
        wait_read();
        total++;
        if (state !== 2'd2 || err !== 1'b0) begin
            bad++; $display("FAIL err_pre: state=%0d err=%b want 2/0", state, err);
        end
        for (int cyc = 0; cyc < 20 && rel == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) bank_full = 2'b00;
            #1;
            if (cyc == 1) begin
                total++;
                if (err !== 1'b1) begin bad++; $display("FAIL err_set: err=%b want 1", err); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (out_data !== exp_word(0, pops)) begin
                    bad++; $display("FAIL err_word %0d: data=%h want %h", pops, out_data, exp_word(0, pops));
                end
                pops++;
            end
            if (bank_release !== 2'b00) begin
                total++;
                if (bank_release !== 2'b01 || pops != 4) begin
                    bad++; $display("FAIL err_rel: rel=%b words=%0d want 01/4", bank_release, pops);
                end
                rel++;
            end
        end
        repeat (3) begin @(negedge clk); #1; end
        total++;
        if (err !== 1'b1 || rel != 1 || state !== 2'd1) begin
            bad++; $display("FAIL err_sticky: err=%b releases=%0d state=%0d want 1/1/1", err, rel, state);
        end
        bank_full = 2'b10;
        wait_read();
        total++;
        if (state !== 2'd2 || cur_bank !== 1'b1) begin
            bad++; $display("FAIL err_read1: state=%0d bank=%b want 2/1", state, cur_bank);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (err !== 1'b0 || state !== 2'd0 || bank_release !== 2'b00) begin
            bad++; $display("FAIL err_rst: err=%b state=%0d rel=%b want 0/0/00", err, state, bank_release);
        end
        @(negedge clk);
        rst = 1'b0; run = 1'b0; bank_full = 2'b00;
        repeat (4) begin
            @(negedge clk); #1;
            if (bank_release !== 2'b00) rel_seen = 1'b1;
        end
        total++;
        if (rel_seen || state !== 2'd0 || err !== 1'b0) begin
            bad++; $display("FAIL err_abandon: release_seen=%b state=%0d err=%b want 0/0/0", rel_seen, state, err);
        end
    endtask

    initial begin
        for (int i = 0; i < 2 * DEPTH; i++) ram[i] = 16'h5A00 + 16'(i * 17);
        rst = 1'b1; run = 1'b0; bank_full = 2'b00; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_both_banks();
        test_run_drop();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
